// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, LANES bits per clock, per-word MSB/LSB-first order.
// Latency: beat 0 appears one cycle after accept; back-to-back words stream with no gap.
// Backpressure: s_ready drops while the one-entry hold buffer is full; optional PISO_PARITY_EN adds a parity beat.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_msb_first,
  output logic [LANES-1:0] sout,
  output logic             sout_valid,
  output logic             sout_sof,
  output logic             sout_eof
);

  localparam int BEATS = WIDTH / LANES;
`ifdef PISO_PARITY_EN
  localparam int FRAME = BEATS + 1;
`else
  localparam int FRAME = BEATS;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  // A word must split into a whole number of beats, and at least two of them.
  if ((WIDTH % LANES) != 0 || (WIDTH / LANES) < 2) begin : g_param_check
    $fatal(1, "piso_serializer: WIDTH must be a multiple of LANES with WIDTH/LANES >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_msb, w_msb_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hold_dat, w_hold_dat_nxt;
  logic             r_hold_msb, w_hold_msb_nxt;
  logic             r_hold_full, w_hold_full_nxt;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  logic             w_accept;
  logic             w_last;
  logic [LANES-1:0] w_beat;

  assign s_ready  = !r_hold_full;
  assign w_accept = s_valid && !r_hold_full;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: shift word, beat counter, hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_msb       <= 1'b0;
      r_cnt       <= '0;
      r_hold_dat  <= '0;
      r_hold_msb  <= 1'b0;
      r_hold_full <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_shift     <= w_shift_nxt;
      r_msb       <= w_msb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_dat  <= w_hold_dat_nxt;
      r_hold_msb  <= w_hold_msb_nxt;
      r_hold_full <= w_hold_full_nxt;
`ifdef PISO_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  // Next-state logic: load from input or hold buffer, advance beats, refill hold buffer.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_msb_nxt       = r_msb;
    w_cnt_nxt       = r_cnt;
    w_hold_dat_nxt  = r_hold_dat;
    w_hold_msb_nxt  = r_hold_msb;
    w_hold_full_nxt = r_hold_full;
`ifdef PISO_PARITY_EN
    w_par_nxt       = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = s_data;
          w_msb_nxt   = s_msb_first;
          w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
          w_par_nxt   = ^s_data;
`endif
        end
      end
      SHIFT: begin
        if (w_last) begin
          if (r_hold_full) begin
            // Held word follows immediately; the hold buffer frees up.
            w_shift_nxt     = r_hold_dat;
            w_msb_nxt       = r_hold_msb;
            w_cnt_nxt       = '0;
            w_hold_full_nxt = 1'b0;
`ifdef PISO_PARITY_EN
            w_par_nxt       = ^r_hold_dat;
`endif
          end else if (w_accept) begin
            // Word arriving on the last beat bypasses the hold buffer.
            w_shift_nxt = s_data;
            w_msb_nxt   = s_msb_first;
            w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
            w_par_nxt   = ^s_data;
`endif
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_shift_nxt = r_msb ? (r_shift << LANES) : (r_shift >> LANES);
          w_cnt_nxt   = r_cnt + CW'(1);
          if (w_accept) begin
            w_hold_dat_nxt  = s_data;
            w_hold_msb_nxt  = s_msb_first;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output beat: top lanes for MSB-first, bottom lanes for LSB-first; zero when idle.
  always_comb begin
    w_beat     = r_msb ? r_shift[WIDTH-1 -: LANES] : r_shift[LANES-1:0];
    sout_valid = (r_state == SHIFT);
    sout_sof   = sout_valid && (r_cnt == '0);
    sout_eof   = sout_valid && (r_cnt == LAST);
    sout       = '0;
    if (sout_valid) begin
`ifdef PISO_PARITY_EN
      if (r_cnt == CW'(BEATS)) begin
        sout[0] = r_par;
      end else begin
        sout = w_beat;
      end
`else
      sout = w_beat;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: two instances (LANES=1 and LANES=2, WIDTH=8).
// Inputs change one time unit after the rising edge; outputs are sampled on the falling edge.
// Expected beat sequences and parities are hand-written per word.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

`ifdef PISO_PARITY_EN
  localparam int FR  = 9;
  localparam int FR2 = 5;
`else
  localparam int FR  = 8;
  localparam int FR2 = 4;
`endif

  int total = 0;
  int bad   = 0;

  // LANES=1 instance
  logic       a_valid, a_ready, a_msb, a_vld, a_sof, a_eof;
  logic [7:0] a_data;
  logic [0:0] a_sout;

  // LANES=2 instance
  logic       b_valid, b_ready, b_msb, b_vld, b_sof, b_eof;
  logic [7:0] b_data;
  logic [1:0] b_sout;

  piso_serializer #(.WIDTH(8), .LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_msb_first(a_msb),
    .sout(a_sout), .sout_valid(a_vld), .sout_sof(a_sof), .sout_eof(a_eof)
  );

  piso_serializer #(.WIDTH(8), .LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_msb_first(b_msb),
    .sout(b_sout), .sout_valid(b_vld), .sout_sof(b_sof), .sout_eof(b_eof)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00; a_msb = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_msb = 1'b0;
    #12;
    total++;
    if ({a_vld, a_sof, a_eof, a_sout} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_out_a: got %b want 0000", {a_vld, a_sof, a_eof, a_sout});
    end
    total++;
    if ({b_vld, b_sof, b_eof, b_sout} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_out_b: got %b want 00000", {b_vld, b_sof, b_eof, b_sout});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({a_ready, b_ready, a_vld, b_vld} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1100", {a_ready, b_ready, a_vld, b_vld});
    end
  endtask

  // One word on the LANES=1 instance; seq[7] is beat 0, par is the expected parity beat.
  task automatic test_frame(input logic [7:0] w, input logic msb, input logic [7:0] seq,
                            input logic par, input string nm);
    logic [7:0] s;
    logic       expb;
    logic [3:0] exp4;
    s = seq;
    @(posedge clk); #1;
    a_data = w; a_msb = msb; a_valid = 1'b1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got %b want 1", nm, a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = 8'h00;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      expb = (k < 8) ? s[7-k] : par;
      exp4 = {1'b1, (k == 0), (k == FR - 1), expb};
      total++;
      if ({a_vld, a_sof, a_eof, a_sout} !== exp4) begin
        bad++;
        $display("FAIL %s_beat%0d: got vld/sof/eof/sout=%b want %b", nm, k,
                 {a_vld, a_sof, a_eof, a_sout}, exp4);
      end
    end
    @(negedge clk);
    total++;
    if ({a_vld, a_sof, a_eof, a_sout} !== 4'b0000) begin
      bad++;
      $display("FAIL %s_idle: got %b want 0000", nm, {a_vld, a_sof, a_eof, a_sout});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] seqs  [3];
    logic       pars  [3];
    int         idx;
    int         b, wi, k;
    logic       acc, exp_rdy, expb;
    logic [3:0] exp4;
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
    seqs[0]  = 8'b00010010; seqs[1] = 8'b00110100; seqs[2] = 8'b01010110;
    pars[0]  = 1'b0; pars[1] = 1'b1; pars[2] = 1'b0;
    idx = 0;
    @(posedge clk); #1;
    a_valid = 1'b1; a_msb = 1'b1; a_data = words[0];
    for (int c = 0; c <= 3 * FR + 1; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3 * FR) begin
        b  = c - 1;
        wi = b / FR;
        k  = b % FR;
        expb = (k < 8) ? seqs[wi][7-k] : pars[wi];
        exp4 = {1'b1, (k == 0), (k == FR - 1), expb};
      end else begin
        exp4 = 4'b0000;
      end
      total++;
      if ({a_vld, a_sof, a_eof, a_sout} !== exp4) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got vld/sof/eof/sout=%b want %b", c,
                 {a_vld, a_sof, a_eof, a_sout}, exp4);
      end
      exp_rdy = !((c >= 2 && c <= FR) || (c >= FR + 2 && c <= 2 * FR));
      total++;
      if (a_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready%0d: got %b want %b", c, a_ready, exp_rdy);
      end
      acc = a_valid && a_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx >= 3) begin
        a_valid = 1'b0; a_data = 8'h00;
      end else begin
        a_data = words[idx];
      end
    end
  endtask

  // One word on the LANES=2 instance; beat 0 is seq[7:6].
  task automatic test_lanes2(input logic [7:0] w, input logic msb, input logic [7:0] seq,
                             input logic par, input string nm);
    logic [7:0] s;
    logic [1:0] expd;
    logic [4:0] exp5;
    s = seq;
    @(posedge clk); #1;
    b_data = w; b_msb = msb; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_data = 8'h00;
    for (int k = 0; k < FR2; k++) begin
      @(negedge clk);
      expd = (k < 4) ? s[7-2*k -: 2] : {1'b0, par};
      exp5 = {1'b1, (k == 0), (k == FR2 - 1), expd};
      total++;
      if ({b_vld, b_sof, b_eof, b_sout} !== exp5) begin
        bad++;
        $display("FAIL %s_beat%0d: got vld/sof/eof/sout=%b want %b", nm, k,
                 {b_vld, b_sof, b_eof, b_sout}, exp5);
      end
    end
    @(negedge clk);
    total++;
    if ({b_vld, b_sof, b_eof, b_sout} !== 5'b00000) begin
      bad++;
      $display("FAIL %s_idle: got %b want 00000", nm, {b_vld, b_sof, b_eof, b_sout});
    end
  endtask

  task automatic test_reset_mid_word();
    @(posedge clk); #1;
    a_valid = 1'b1; a_msb = 1'b1; a_data = 8'hFF;
    @(posedge clk); #1;
    a_data = 8'h0F;
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = 8'h00;
    @(posedge clk);
    @(posedge clk); #2;
    total++;
    if ({a_vld, a_sof, a_eof, a_sout, a_ready} !== 5'b10010) begin
      bad++;
      $display("FAIL rstmid_pre: got vld/sof/eof/sout/rdy=%b want 10010",
               {a_vld, a_sof, a_eof, a_sout, a_ready});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({a_vld, a_sof, a_eof, a_sout} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_async: got %b want 0000", {a_vld, a_sof, a_eof, a_sout});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FR + 2; i++) begin
      @(negedge clk);
      total++;
      if ({a_vld, a_sof, a_eof, a_sout, a_ready} !== 5'b00001) begin
        bad++;
        $display("FAIL rstmid_after%0d: got vld/sof/eof/sout/rdy=%b want 00001", i,
                 {a_vld, a_sof, a_eof, a_sout, a_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b1, 8'b10100101, 1'b0, "msb_a5");
    test_frame(8'hA5, 1'b0, 8'b10100101, 1'b0, "lsb_a5");
    test_frame(8'h01, 1'b0, 8'b10000000, 1'b1, "lsb_01");
    test_frame(8'h80, 1'b1, 8'b10000000, 1'b1, "msb_80");
    test_back_to_back();
    test_lanes2(8'hB4, 1'b1, 8'b10110100, 1'b0, "l2_msb_b4");
    test_lanes2(8'hB4, 1'b0, 8'b00011110, 1'b0, "l2_lsb_b4");
    test_reset_mid_word();
    test_frame(8'h07, 1'b1, 8'b00000111, 1'b1, "par_07");
    test_frame(8'h03, 1'b1, 8'b00000011, 1'b0, "par_03");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
